// File: rtl/nibble_serial_accumulator.sv
// Nibble-serial frame accumulator: each accepted 4-bit operand is added into
// an ACC_W-bit accumulator one nibble per cycle through a single 4-bit adder.
// A frame ends on an operand flagged in_last; its sum, sticky overflow and
// operand count are then offered on a valid/ready output handshake.

module full_adder_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);
  assign {c_out, s} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
endmodule

module nibble_serial_accumulator #(
  parameter int ACC_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);
  localparam int NIB = ACC_W / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic             carry;
  logic [KW-1:0]    k;
  logic [3:0]       opnd;
  logic             last_r;
  logic             ovf;
  logic [CNT_W-1:0] cnt;

  logic             k_first, k_last;
  logic [3:0]       fa_a, fa_b, fa_s;
  logic             fa_ci, fa_co;

  assign k_first = (k == '0);
  assign k_last  = (k == K_LAST);

  // The operand enters only on nibble 0; higher nibbles just ripple the carry.
  assign fa_a  = acc[{k, 2'b00} +: 4];
  assign fa_b  = k_first ? opnd : 4'h0;
  assign fa_ci = k_first ? 1'b0 : carry;

  full_adder_4b u_fa (
    .a     (fa_a),
    .b     (fa_b),
    .c_in  (fa_ci),
    .s     (fa_s),
    .c_out (fa_co)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: ADD walks all nibbles, then DONE only if the frame closed
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = ADD;
      ADD:     if (k_last)    state_nxt = last_r ? DONE : IDLE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, nibble-serial add, frame clear
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      carry  <= 1'b0;
      k      <= '0;
      opnd   <= 4'h0;
      last_r <= 1'b0;
      ovf    <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          opnd   <= in_data;
          last_r <= in_last;
          k      <= '0;
          carry  <= 1'b0;
          if (cnt != '1) cnt <= cnt + CNT_W'(1);
        end
        ADD: begin
          acc[{k, 2'b00} +: 4] <= fa_s;
          carry <= fa_co;
          k     <= k_last ? '0 : k + KW'(1);
          if (k_last && fa_co) ovf <= 1'b1;
        end
        DONE: if (out_ready) begin
          acc <= '0;
          ovf <= 1'b0;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign out_sum   = acc;
  assign out_ovf   = ovf;
  assign out_count = cnt;

endmodule

// File: tb/tb_nibble_serial_accumulator.sv
// Bench for nibble_serial_accumulator: a frame-level model (running integer
// sum, operand count, busy countdown) checked every cycle, plus directed
// literal checks on the hand-computed frames.

module tb_nibble_serial_accumulator;
  localparam int ACC_W = 8;
  localparam int CNT_W = 8;
  localparam int NIB   = ACC_W / 4;
  localparam longint MOD  = longint'(1) << ACC_W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_data = 4'h0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  nibble_serial_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: busy counts remaining serial-add cycles
  int     m_busy = 0;
  bit     m_done = 1'b0;
  bit     m_pend = 1'b0;
  bit     m_acc  = 1'b0;
  longint m_sum  = 0;
  int     m_cnt  = 0;

  always @(posedge clk) begin
    m_acc = 1'b0;
    if (rst) begin
      m_busy = 0; m_done = 1'b0; m_sum = 0; m_cnt = 0;
    end else if (m_done) begin
      if (out_ready) begin m_done = 1'b0; m_sum = 0; m_cnt = 0; end
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0 && m_pend) m_done = 1'b1;
    end else if (in_valid) begin
      m_sum  += longint'(in_data);
      m_cnt  = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      m_pend = in_last;
      m_busy = NIB;
      m_acc  = 1'b1;
    end
  end

  // Per-cycle compare; sum/ovf are only meaningful when no add is in flight
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  longint'(in_ready),  longint'(!m_done && m_busy == 0));
      chk("out_valid", longint'(out_valid), longint'(m_done));
      chk("out_count", longint'(out_count), longint'(m_cnt));
      if (m_busy == 0) begin
        chk("out_sum", longint'(out_sum), m_sum % MOD);
        chk("out_ovf", longint'(out_ovf), longint'(m_sum >= MOD));
      end
    end
  end

  // Present one operand until accepted, then wiggle in_valid while busy
  task automatic send(input logic [3:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    do begin @(negedge clk); t++; end while (!m_acc && t < 100);
    if (!m_acc) chk("send_timeout", longint'(t), 0);
    in_valid = 1'($urandom_range(0, 1));
    in_data  = 4'($urandom);
    in_last  = 1'($urandom_range(0, 1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    if (!out_valid) chk(nm, 0, 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(m_busy == 0 && !m_done) && t < 500) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      t++;
    end
    if (t >= 500) chk("idle_timeout", longint'(t), 0);
  endtask

  initial begin
    // reset for two cycles
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_in_ready",  longint'(in_ready),  1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_sum",   longint'(out_sum),   0);
    chk("rst_out_ovf",   longint'(out_ovf),   0);
    chk("rst_out_count", longint'(out_count), 0);
    rst = 1'b0;
    @(negedge clk);

    // F+F+F = 45, out_valid exactly one cycle
    out_ready = 1'b1;
    send(4'hF, 1'b0); send(4'hF, 1'b0); send(4'hF, 1'b1);
    wait_done("f3_done");
    chk("f3_sum",   longint'(out_sum),   45);
    chk("f3_ovf",   longint'(out_ovf),   0);
    chk("f3_count", longint'(out_count), 3);
    @(negedge clk);
    chk("f3_pulse", longint'(out_valid), 0);

    // inter-nibble carry: F+1 = 0x10
    send(4'hF, 1'b0); send(4'h1, 1'b1);
    wait_done("carry_done");
    chk("carry_sum", longint'(out_sum), 'h10);
    chk("carry_ovf", longint'(out_ovf), 0);
    @(negedge clk);

    // 18 x F = 270 -> wraps to 0x0E with overflow
    for (int i = 0; i < 18; i++) send(4'hF, 1'(i == 17));
    wait_done("wrap_done");
    chk("wrap_sum",   longint'(out_sum),   'h0E);
    chk("wrap_ovf",   longint'(out_ovf),   1);
    chk("wrap_count", longint'(out_count), 18);
    @(negedge clk);

    // single-operand frame held in DONE by back-pressure
    out_ready = 1'b0;
    send(4'h3, 1'b1);
    wait_done("hold_done");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid",    longint'(out_valid), 1);
      chk("hold_sum",      longint'(out_sum),   3);
      chk("hold_count",    longint'(out_count), 1);
      chk("hold_in_ready", longint'(in_ready),  0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", longint'(in_ready), 1);
    chk("release_sum",      longint'(out_sum),  0);

    // reset in the second ADD cycle with acc = 0x25
    send(4'hF, 1'b0); send(4'hF, 1'b0); send(4'h7, 1'b0);
    @(negedge clk);
    chk("pre_rst_sum", longint'(out_sum), 'h25);
    send(4'h5, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", longint'(in_ready),  1);
    chk("mid_rst_sum",      longint'(out_sum),   0);
    chk("mid_rst_count",    longint'(out_count), 0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_valid", longint'(out_valid), 0);
    end

    // random frames with random back-pressure
    for (int f = 0; f < 12; f++) begin
      int n = $urandom_range(1, 24);
      out_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) send(4'($urandom), 1'(i == n - 1));
      wait_idle();
    end

    // count saturation at 2^CNT_W-1
    out_ready = 1'b0;
    for (int i = 0; i < CMAX + 5; i++) send(4'($urandom), 1'(i == CMAX + 4));
    wait_done("sat_done");
    chk("sat_count", longint'(out_count), CMAX);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
